// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-setting controller.
// Contents: FSM state encoding, BCD digit limits, default timing parameters,
// and a helper that checks whether a BCD digit pair lies inside a field range.
package watch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } watch_state_e;

  localparam logic [3:0] HOUR_MAX_DEZ      = 4'd2;
  localparam logic [3:0] HOUR_MAX_UNI_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_DEZ       = 4'd5;
  localparam logic [3:0] DIGIT_MAX         = 4'd9;

  localparam int DEFAULT_CLK_HZ     = 50_000_000;
  localparam int DEFAULT_BLINK_HALF = 12_500_000;
  localparam int DEFAULT_TIMEOUT_S  = 30;

  // True when dez:uni is a legal BCD value not above max_dez:max_uni_at_max_dez.
  function automatic logic bcd_pair_legal(input logic [3:0] dez,
                                          input logic [3:0] uni,
                                          input logic [3:0] max_dez,
                                          input logic [3:0] max_uni_at_max_dez);
    return (uni <= DIGIT_MAX) &&
           ((dez < max_dez) || ((dez == max_dez) && (uni <= max_uni_at_max_dez)));
  endfunction

endpackage

// File: rtl/watch_set_ctrl_bcd_field_inc.sv
// bcd_field_inc: combinational +1 on a two-digit BCD field with wrap to 00.
// Ports:
//   dez, uni            in  4  current tens / units digit
//   max_dez             in  4  highest legal tens digit of the field
//   max_uni_at_max_dez  in  4  highest legal units digit when dez == max_dez
//   dez_inc, uni_inc    out 4  incremented field
// An out-of-range input also wraps to 00, so the result is always legal BCD.
module bcd_field_inc
  import watch_pkg::*;
(
  input  logic [3:0] dez,
  input  logic [3:0] uni,
  input  logic [3:0] max_dez,
  input  logic [3:0] max_uni_at_max_dez,
  output logic [3:0] dez_inc,
  output logic [3:0] uni_inc
);

  always_comb begin
    dez_inc = dez;
    uni_inc = uni;
    if ((dez > max_dez) || ((dez == max_dez) && (uni >= max_uni_at_max_dez))) begin
      dez_inc = 4'd0;
      uni_inc = 4'd0;
    end else if (uni >= DIGIT_MAX) begin
      dez_inc = dez + 4'd1;
      uni_inc = 4'd0;
    end else begin
      uni_inc = uni + 4'd1;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: time-setting controller for the BCD HH:MM:SS watch counter.
// Switches the counter between run and set modes, edits shadow HH:MM with
// three buttons, issues a one-cycle load strobe on commit and drives blink masks.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   btn_mode, btn_inc, btn_clr debounced button levels (rising edge = action)
//   cur_h_*/cur_m_*            live BCD time from the counter
//   cnt_enable                 counter run enable (decoded from state)
//   cnt_clr                    one-cycle counter clear pulse
//   load_stb, load_*           one-cycle load strobe and shadow BCD digits
//   blink_h, blink_m           1 = blank that field this cycle
//   mode                       current state encoding
// Optional build macro: WATCH_SET_AUTOREPEAT_EN (held btn_inc auto-repeats).
//
// state  | meaning
// RUN    | counter running; mode edge enters editing, clr edge pulses cnt_clr
// SET_H  | counter frozen; editing shadow hours
// SET_M  | counter frozen; editing shadow minutes
// COMMIT | single cycle; load_stb asserted, then back to RUN
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int BLINK_HALF = DEFAULT_BLINK_HALF,
  parameter int TIMEOUT_S  = DEFAULT_TIMEOUT_S
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  input  logic [3:0] cur_h_dez,
  input  logic [3:0] cur_h_uni,
  input  logic [3:0] cur_m_dez,
  input  logic [3:0] cur_m_uni,
  output logic       cnt_enable,
  output logic       cnt_clr,
  output logic       load_stb,
  output logic [3:0] load_h_dez,
  output logic [3:0] load_h_uni,
  output logic [3:0] load_m_dez,
  output logic [3:0] load_m_uni,
  output logic       blink_h,
  output logic       blink_m,
  output logic [1:0] mode
);

  localparam int TICK_W  = $clog2(CLK_HZ + 1);
  localparam int SEC_W   = $clog2(TIMEOUT_S + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  localparam logic [TICK_W-1:0]  TICK_RELOAD  = TICK_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0]   SEC_RELOAD   = SEC_W'(TIMEOUT_S - 1);
  localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_HALF - 1);

  watch_state_e state_q, state_nxt;

  logic mode_prev_q, inc_prev_q, clr_prev_q;
  logic mode_e, inc_e, clr_e;
  logic clr_ev, mode_ev, inc_ev, rep_ev, inc_act, btn_event;
  logic in_set, in_set_nxt, state_chg, timeout;

  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_nxt;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_nxt;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_nxt;
  logic               phase_q, phase_nxt;

  logic [3:0] sh_h_dez_q, sh_h_uni_q, sh_m_dez_q, sh_m_uni_q;
  logic [3:0] sh_h_dez_nxt, sh_h_uni_nxt, sh_m_dez_nxt, sh_m_uni_nxt;
  logic [3:0] h_dez_inc, h_uni_inc, m_dez_inc, m_uni_inc;

  logic cnt_clr_nxt, load_stb_nxt, blink_h_nxt, blink_m_nxt;

  // Button edges; clr outranks mode outranks inc, losers are dropped.
  assign mode_e    = btn_mode & ~mode_prev_q;
  assign inc_e     = btn_inc  & ~inc_prev_q;
  assign clr_e     = btn_clr  & ~clr_prev_q;
  assign clr_ev    = clr_e;
  assign mode_ev   = mode_e & ~clr_e;
  assign inc_ev    = inc_e & ~clr_e & ~mode_e;
  assign inc_act   = inc_ev | rep_ev;
  assign btn_event = mode_e | inc_e | clr_e | rep_ev;

  assign in_set  = (state_q == SET_H) || (state_q == SET_M);
  assign timeout = in_set && !btn_event && (tick_cnt_q == '0) && (sec_cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      clr_prev_q  <= 1'b0;
    end else begin
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      clr_prev_q  <= btn_clr;
    end
  end

`ifdef WATCH_SET_AUTOREPEAT_EN
  localparam int REP_FAST_I = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam logic [TICK_W-1:0] REP_FAST_RELOAD = TICK_W'(REP_FAST_I - 1);

  logic [TICK_W-1:0] rep_cnt_q;
  logic              rep_armed_q;

  // Armed only by a real inc edge in a set state, so a button already held
  // when entering SET_H cannot fire repeats.
  assign rep_ev = rep_armed_q && in_set && btn_inc && !inc_e && !clr_e && !mode_e &&
                  (rep_cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (!in_set || !btn_inc) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (inc_e) begin
      rep_cnt_q   <= TICK_RELOAD;
      rep_armed_q <= 1'b1;
    end else if (rep_armed_q) begin
      if (rep_cnt_q == '0) rep_cnt_q <= REP_FAST_RELOAD;
      else                 rep_cnt_q <= rep_cnt_q - TICK_W'(1);
    end
  end
`else
  assign rep_ev = 1'b0;
`endif

  bcd_field_inc u_hour_inc (
    .dez                (sh_h_dez_q),
    .uni                (sh_h_uni_q),
    .max_dez            (HOUR_MAX_DEZ),
    .max_uni_at_max_dez (HOUR_MAX_UNI_AT_2),
    .dez_inc            (h_dez_inc),
    .uni_inc            (h_uni_inc)
  );

  bcd_field_inc u_min_inc (
    .dez                (sh_m_dez_q),
    .uni                (sh_m_uni_q),
    .max_dez            (MIN_MAX_DEZ),
    .max_uni_at_max_dez (DIGIT_MAX),
    .dez_inc            (m_dez_inc),
    .uni_inc            (m_uni_inc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN:     if (mode_ev) state_nxt = SET_H;
      SET_H: begin
        if (timeout)      state_nxt = RUN;
        else if (mode_ev) state_nxt = SET_M;
      end
      SET_M: begin
        if (timeout)      state_nxt = RUN;
        else if (mode_ev) state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign in_set_nxt = (state_nxt == SET_H) || (state_nxt == SET_M);
  assign state_chg  = (state_nxt != state_q);

  // Timers, blink phase and shadow digits
  always_comb begin
    tick_cnt_nxt  = tick_cnt_q;
    sec_cnt_nxt   = sec_cnt_q;
    blink_cnt_nxt = blink_cnt_q;
    phase_nxt     = phase_q;
    sh_h_dez_nxt  = sh_h_dez_q;
    sh_h_uni_nxt  = sh_h_uni_q;
    sh_m_dez_nxt  = sh_m_dez_q;
    sh_m_uni_nxt  = sh_m_uni_q;

    if (!in_set_nxt) begin
      tick_cnt_nxt = '0;
      sec_cnt_nxt  = '0;
    end else if (btn_event || state_chg) begin
      tick_cnt_nxt = TICK_RELOAD;
      sec_cnt_nxt  = SEC_RELOAD;
    end else if (tick_cnt_q == '0) begin
      tick_cnt_nxt = TICK_RELOAD;
      sec_cnt_nxt  = sec_cnt_q - SEC_W'(1);
    end else begin
      tick_cnt_nxt = tick_cnt_q - TICK_W'(1);
    end

    // Restart on entry and on increment so the edited field is visible at once.
    if (!in_set_nxt) begin
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b0;
    end else if (state_chg || inc_act) begin
      blink_cnt_nxt = BLINK_RELOAD;
      phase_nxt     = 1'b0;
    end else if (blink_cnt_q == '0) begin
      blink_cnt_nxt = BLINK_RELOAD;
      phase_nxt     = ~phase_q;
    end else begin
      blink_cnt_nxt = blink_cnt_q - BLINK_W'(1);
    end

    case (state_q)
      RUN: begin
        if (mode_ev) begin
          // An illegal live value is replaced by 00 so the shadow stays legal BCD.
          if (bcd_pair_legal(cur_h_dez, cur_h_uni, HOUR_MAX_DEZ, HOUR_MAX_UNI_AT_2)) begin
            sh_h_dez_nxt = cur_h_dez;
            sh_h_uni_nxt = cur_h_uni;
          end else begin
            sh_h_dez_nxt = 4'd0;
            sh_h_uni_nxt = 4'd0;
          end
          if (bcd_pair_legal(cur_m_dez, cur_m_uni, MIN_MAX_DEZ, DIGIT_MAX)) begin
            sh_m_dez_nxt = cur_m_dez;
            sh_m_uni_nxt = cur_m_uni;
          end else begin
            sh_m_dez_nxt = 4'd0;
            sh_m_uni_nxt = 4'd0;
          end
        end
      end
      SET_H: begin
        if (clr_ev) begin
          sh_h_dez_nxt = 4'd0;
          sh_h_uni_nxt = 4'd0;
        end else if (inc_act) begin
          sh_h_dez_nxt = h_dez_inc;
          sh_h_uni_nxt = h_uni_inc;
        end
      end
      SET_M: begin
        if (clr_ev) begin
          sh_m_dez_nxt = 4'd0;
          sh_m_uni_nxt = 4'd0;
        end else if (inc_act) begin
          sh_m_dez_nxt = m_dez_inc;
          sh_m_uni_nxt = m_uni_inc;
        end
      end
      default: ;
    endcase

    if (timeout) begin
      sh_h_dez_nxt = 4'd0;
      sh_h_uni_nxt = 4'd0;
      sh_m_dez_nxt = 4'd0;
      sh_m_uni_nxt = 4'd0;
    end
  end

  // Output logic; registered outputs are computed from next-state values so
  // they line up with the state register.
  always_comb begin
    cnt_enable   = (state_q == RUN);
    cnt_clr_nxt  = (state_q == RUN) && clr_ev;
    load_stb_nxt = (state_nxt == COMMIT);
    blink_h_nxt  = (state_nxt == SET_H) && phase_nxt;
    blink_m_nxt  = (state_nxt == SET_M) && phase_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      sec_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      sh_h_dez_q  <= 4'd0;
      sh_h_uni_q  <= 4'd0;
      sh_m_dez_q  <= 4'd0;
      sh_m_uni_q  <= 4'd0;
      cnt_clr     <= 1'b0;
      load_stb    <= 1'b0;
      blink_h     <= 1'b0;
      blink_m     <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_nxt;
      sec_cnt_q   <= sec_cnt_nxt;
      blink_cnt_q <= blink_cnt_nxt;
      phase_q     <= phase_nxt;
      sh_h_dez_q  <= sh_h_dez_nxt;
      sh_h_uni_q  <= sh_h_uni_nxt;
      sh_m_dez_q  <= sh_m_dez_nxt;
      sh_m_uni_q  <= sh_m_uni_nxt;
      cnt_clr     <= cnt_clr_nxt;
      load_stb    <= load_stb_nxt;
      blink_h     <= blink_h_nxt;
      blink_m     <= blink_m_nxt;
    end
  end

  assign load_h_dez = sh_h_dez_q;
  assign load_h_uni = sh_h_uni_q;
  assign load_m_dez = sh_m_dez_q;
  assign load_m_uni = sh_m_uni_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl with CLK_HZ=10, BLINK_HALF=4, TIMEOUT_S=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_watch_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_clr = 1'b0;
  logic [3:0] cur_h_dez = 4'd0, cur_h_uni = 4'd0, cur_m_dez = 4'd0, cur_m_uni = 4'd0;
  logic       cnt_enable, cnt_clr, load_stb, blink_h, blink_m;
  logic [3:0] load_h_dez, load_h_uni, load_m_dez, load_m_uni;
  logic [1:0] mode;

  int n_checks = 0;
  int n_errors = 0;

  watch_set_ctrl #(.CLK_HZ(10), .BLINK_HALF(4), .TIMEOUT_S(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_clr    (btn_clr),
    .cur_h_dez  (cur_h_dez),
    .cur_h_uni  (cur_h_uni),
    .cur_m_dez  (cur_m_dez),
    .cur_m_uni  (cur_m_uni),
    .cnt_enable (cnt_enable),
    .cnt_clr    (cnt_clr),
    .load_stb   (load_stb),
    .load_h_dez (load_h_dez),
    .load_h_uni (load_h_uni),
    .load_m_dez (load_m_dez),
    .load_m_uni (load_m_uni),
    .blink_h    (blink_h),
    .blink_m    (blink_m),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_load(input string tag, input int hd, input int hu, input int md, input int mu);
    chk({tag, "_h_dez"}, 32'(load_h_dez), 32'(hd));
    chk({tag, "_h_uni"}, 32'(load_h_uni), 32'(hu));
    chk({tag, "_m_dez"}, 32'(load_m_dez), 32'(md));
    chk({tag, "_m_uni"}, 32'(load_m_uni), 32'(mu));
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; @(negedge clk);
    btn_mode = 1'b0; @(negedge clk);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; @(negedge clk);
    btn_inc = 1'b0; @(negedge clk);
  endtask

  task automatic set_cur(input logic [3:0] hd, input logic [3:0] hu,
                         input logic [3:0] md, input logic [3:0] mu);
    cur_h_dez = hd; cur_h_uni = hu; cur_m_dez = md; cur_m_uni = mu;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] pat;
    logic       seen_stb;
    bit         left;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_mode", 32'(mode), 0);
    chk("rst_cnt_enable", 32'(cnt_enable), 1);
    chk("rst_cnt_clr", 32'(cnt_clr), 0);
    chk("rst_load_stb", 32'(load_stb), 0);
    chk("rst_blink_h", 32'(blink_h), 0);
    chk("rst_blink_m", 32'(blink_m), 0);
    chk_load("rst_load", 0, 0, 0, 0);

    // clr and mode rising together in RUN: clr wins
    btn_clr = 1'b1; btn_mode = 1'b1;
    @(negedge clk);
    chk("clrmode_cnt_clr", 32'(cnt_clr), 1);
    chk("clrmode_mode", 32'(mode), 0);
    btn_clr = 1'b0; btn_mode = 1'b0;
    @(negedge clk);
    chk("clrmode_cnt_clr_end", 32'(cnt_clr), 0);
    chk("clrmode_mode_after", 32'(mode), 0);

    // inc in RUN is ignored
    press_inc();
    chk("run_inc_mode", 32'(mode), 0);
    chk("run_inc_enable", 32'(cnt_enable), 1);

    // Full edit: 13:47, 11 increments on hours -> 00:47
    set_cur(4'd1, 4'd3, 4'd4, 4'd7);
    press_mode();
    chk("seth_mode", 32'(mode), 1);
    chk("seth_enable", 32'(cnt_enable), 0);
    chk_load("seth_capture", 1, 3, 4, 7);
    for (int i = 0; i < 11; i++) press_inc();
    chk_load("seth_after11", 0, 0, 4, 7);
    press_mode();
    chk("setm_mode", 32'(mode), 2);
    btn_mode = 1'b1;
    @(negedge clk);
    chk("commit_mode", 32'(mode), 3);
    chk("commit_load_stb", 32'(load_stb), 1);
    chk("commit_cnt_enable", 32'(cnt_enable), 0);
    chk("commit_cnt_clr", 32'(cnt_clr), 0);
    chk_load("commit_load", 0, 0, 4, 7);
    btn_mode = 1'b0;
    @(negedge clk);
    chk("post_commit_mode", 32'(mode), 0);
    chk("post_commit_stb", 32'(load_stb), 0);
    chk("post_commit_enable", 32'(cnt_enable), 1);

    // Held inc yields a single increment: 19 -> 20
    set_cur(4'd1, 4'd9, 4'd3, 4'd0);
    press_mode();
    btn_inc = 1'b1;
    repeat (5) @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    chk_load("held_inc", 2, 0, 3, 0);
    press_mode();
    press_mode();
    chk("held_exit_mode", 32'(mode), 0);

    // Minute wrap 58 -> 59 -> 00 -> 01
    set_cur(4'd1, 4'd2, 4'd5, 4'd8);
    press_mode();
    press_mode();
    chk("wrap_mode", 32'(mode), 2);
    press_inc();
    chk_load("min59", 1, 2, 5, 9);
    press_inc();
    chk_load("min00", 1, 2, 0, 0);
    press_inc();
    chk_load("min01", 1, 2, 0, 1);

    // Reset mid-SET_M acts immediately
    rst = 1'b1;
    #1;
    chk("midrst_mode", 32'(mode), 0);
    chk("midrst_enable", 32'(cnt_enable), 1);
    chk("midrst_stb", 32'(load_stb), 0);
    chk_load("midrst_load", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Blink in SET_H: 4 cycles per half; inc restarts at phase 0
    set_cur(4'd0, 4'd8, 4'd1, 4'd5);
    press_mode();
    pat = 5'b11000;
    for (int i = 0; i < 5; i++) begin
      chk("blink_h_a", 32'(blink_h), 32'(pat[i]));
      chk("blink_m_a", 32'(blink_m), 0);
      if (i < 4) @(negedge clk);
    end
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    pat = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      chk("blink_h_b", 32'(blink_h), 32'(pat[i]));
      chk("blink_m_b", 32'(blink_m), 0);
      if (i < 4) @(negedge clk);
    end
    chk_load("blink_inc", 0, 9, 1, 5);
    left = 1'b0;
    for (int i = 0; i < 60 && !left; i++) begin
      @(negedge clk);
      if (mode == 2'd0) left = 1'b1;
    end
    chk("blink_left_by_timeout", 32'(left), 1);

    // Timeout: 2 s * 10 cycles with no input -> RUN without load
    @(negedge clk);
    press_mode();
    seen_stb = 1'b0;
    repeat (18) begin
      @(negedge clk);
      if (load_stb) seen_stb = 1'b1;
    end
    chk("timeout_before", 32'(mode), 1);
    @(negedge clk);
    if (load_stb) seen_stb = 1'b1;
    chk("timeout_mode", 32'(mode), 0);
    chk("timeout_enable", 32'(cnt_enable), 1);
    chk("timeout_no_stb", 32'(seen_stb), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
